// File: rtl/chaos_snd_pkg.sv
// Shared encodings and NCO constant derivation for the chaotic sound generator.
package chaos_snd_pkg;

  typedef enum logic {
    MAP_LOGISTIC = 1'b0,
    MAP_TENT     = 1'b1
  } map_mode_e;

  typedef enum logic [1:0] {
    SWEEP_HOLD      = 2'b00,
    SWEEP_UP_WRAP   = 2'b01,
    SWEEP_PING_PONG = 2'b10,
    SWEEP_HOLD_ALT  = 2'b11
  } sweep_mode_e;

  // Clock divider exponent between NCO ticks.
  function automatic int calc_phase_dec(input longint freq, input int phase_bits,
                                        input int freq_res);
    return $clog2(freq) - phase_bits - freq_res;
  endfunction

  // Phase increment for a tone of f Hz at the decimated tick rate.
  function automatic longint calc_inc(input longint f, input int phase_bits,
                                      input int phase_dec, input longint freq);
    return (f << (phase_bits + phase_dec)) / freq;
  endfunction

endpackage

// File: rtl/chaos_snd_map_core.sv
// Iteration counter plus logistic / tent map step; x reseeds when the map hits 0.
module chaos_map_core
  import chaos_snd_pkg::*;
#(
  parameter int FRAC     = 8,
  parameter int ITER_LEN = 100,
  parameter int X_SEED   = 'h80
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            map_mode,
  input  logic [FRAC+1:0] r,
  output logic [FRAC-1:0] x,
  output logic            x_valid
);

  localparam int CNT_W  = $clog2(ITER_LEN);
  localparam int PROD_W = 4 * FRAC + 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_LEN - 1);
  localparam logic [FRAC:0]    ONE      = {1'b1, {FRAC{1'b0}}};
  localparam logic [FRAC-1:0]  SEED     = FRAC'(X_SEED);

  logic [CNT_W-1:0]  r_cnt;
  logic [FRAC-1:0]   r_x;
  logic              r_x_valid;
  logic [FRAC:0]     w_one_minus_x;
  logic [FRAC:0]     w_tent_min;
  logic [PROD_W-1:0] w_logi_prod;
  logic [PROD_W-1:0] w_tent_prod;
  logic [FRAC-1:0]   w_x_next;

  // Products are kept full width so the truncation is a pure floor.
  always_comb begin
    w_one_minus_x = ONE - {1'b0, r_x};
    w_tent_min    = ({1'b0, r_x} < w_one_minus_x) ? {1'b0, r_x} : w_one_minus_x;
    w_logi_prod   = PROD_W'(r) * PROD_W'(r_x) * PROD_W'(w_one_minus_x);
    w_tent_prod   = PROD_W'(r) * PROD_W'(w_tent_min);
    if (map_mode_e'(map_mode) == MAP_TENT) w_x_next = w_tent_prod[FRAC+1 +: FRAC];
    else                                   w_x_next = w_logi_prod[2*FRAC +: FRAC];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_x       <= SEED;
      r_x_valid <= 1'b0;
    end else begin
      r_x_valid <= 1'b0;
      if (r_cnt == CNT_LAST) begin
        r_cnt     <= '0;
        r_x_valid <= 1'b1;
        r_x       <= (w_x_next == '0) ? SEED : w_x_next;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign x       = r_x;
  assign x_valid = r_x_valid;

endmodule

// File: rtl/chaos_snd.sv
// Chaotic tone generator: map-driven r sweep, per-oscillator NCOs and a
// first-order sigma-delta mixer producing a 1-bit PWM audio stream.
module chaos_snd
  import chaos_snd_pkg::*;
#(
  parameter int N_OSC      = 4,
  parameter int FRAC       = 8,
  parameter int ITER_LEN   = 100,
  parameter int R_INC      = 1000,
  parameter int R_MIN      = 'h110,
  parameter int R_MAX      = 'h3FF,
  parameter int R_STEP     = 4,
  parameter int X_SEED     = 'h80,
  parameter int FREQ       = 25_200_000,
  parameter int LO_F       = 200,
  parameter int HI_F       = 1200,
  parameter int PHASE_BITS = 12,
  parameter int FREQ_RES   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            map_mode,
  input  logic [1:0]      sweep_mode,
  input  logic [4:0]      n_active,
  output logic            snd,
  output logic [FRAC-1:0] x_out,
  output logic [FRAC+1:0] r_out,
  output logic            x_valid
);

  localparam int PHASE_DEC = calc_phase_dec(FREQ, PHASE_BITS, FREQ_RES);
  localparam int LO_INC    = int'(calc_inc(LO_F, PHASE_BITS, PHASE_DEC, FREQ));
  localparam int HI_INC    = int'(calc_inc(HI_F, PHASE_BITS, PHASE_DEC, FREQ));
  localparam int RW        = FRAC + 2;
  localparam int RCNT_W    = (R_INC > 1) ? $clog2(R_INC) : 1;
  localparam int TICK_W    = (PHASE_DEC > 0) ? PHASE_DEC : 1;
  localparam int IDX_W     = (N_OSC > 1) ? $clog2(N_OSC) : 1;

  localparam logic [RW:0]       R_MAX_W   = (RW+1)'(R_MAX);
  localparam logic [RW:0]       R_MIN_W   = (RW+1)'(R_MIN);
  localparam logic [RW:0]       R_STEP_W  = (RW+1)'(R_STEP);
  localparam logic [RW-1:0]     R_MIN_R   = RW'(R_MIN);
  localparam logic [RW-1:0]     R_MAX_R   = RW'(R_MAX);
  localparam logic [RW-1:0]     R_STEP_R  = RW'(R_STEP);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(R_INC - 1);

  logic [RW-1:0]         r_r;
  logic                  r_dir_down;
  logic [RCNT_W-1:0]     r_rcnt;
  logic [IDX_W-1:0]      r_fidx;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [PHASE_BITS-1:0] r_freq  [N_OSC];
  logic [PHASE_BITS-1:0] r_phase [N_OSC];
  logic [4:0]            r_acc;
  logic                  r_snd;

  logic [RW:0]           w_r_sum;
  logic [RW-1:0]         w_r_next;
  logic                  w_dir_next;
  logic                  w_sweep_en;
  logic [4:0]            w_n_eff;
  logic [31:0]           w_span_prod;
  logic [PHASE_BITS-1:0] w_freq_new;
  logic                  w_tick;
  logic [4:0]            w_sum;
  logic [5:0]            w_acc_sum;
  logic                  w_fire;

  chaos_map_core #(
    .FRAC     (FRAC),
    .ITER_LEN (ITER_LEN),
    .X_SEED   (X_SEED)
  ) u_map_core (
    .clk      (clk),
    .reset    (reset),
    .map_mode (map_mode),
    .r        (r_r),
    .x        (x_out),
    .x_valid  (x_valid)
  );

  // Down-step compares before subtracting so r never underflows.
  always_comb begin
    w_r_next   = r_r;
    w_dir_next = r_dir_down;
    w_r_sum    = {1'b0, r_r} + R_STEP_W;
    case (sweep_mode_e'(sweep_mode))
      SWEEP_UP_WRAP: w_r_next = (w_r_sum > R_MAX_W) ? R_MIN_R : w_r_sum[RW-1:0];
      SWEEP_PING_PONG: begin
        if (!r_dir_down) begin
          if (w_r_sum >= R_MAX_W) begin
            w_r_next   = R_MAX_R;
            w_dir_next = 1'b1;
          end else begin
            w_r_next = w_r_sum[RW-1:0];
          end
        end else if ({1'b0, r_r} <= R_MIN_W + R_STEP_W) begin
          w_r_next   = R_MIN_R;
          w_dir_next = 1'b0;
        end else begin
          w_r_next = r_r - R_STEP_R;
        end
      end
      default: ;
    endcase
  end

  assign w_sweep_en = x_valid && ((sweep_mode_e'(sweep_mode) == SWEEP_UP_WRAP) ||
                                  (sweep_mode_e'(sweep_mode) == SWEEP_PING_PONG));

  assign w_n_eff     = (n_active == 5'd0) ? 5'd1 :
                       (n_active > 5'(N_OSC)) ? 5'(N_OSC) : n_active;
  assign w_span_prod = 32'(HI_INC - LO_INC) * 32'(x_out);
  assign w_freq_new  = PHASE_BITS'(32'(LO_INC) + (w_span_prod >> FRAC));
  assign w_tick      = (PHASE_DEC == 0) ? 1'b1 : (&r_tick_cnt);

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_OSC; i++) begin
      if (5'(i) < w_n_eff) w_sum = w_sum + 5'(r_phase[i][PHASE_BITS-1]);
    end
    w_acc_sum = {1'b0, r_acc} + {1'b0, w_sum};
    w_fire    = (w_acc_sum >= {1'b0, w_n_eff});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_r        <= R_MIN_R;
      r_dir_down <= 1'b0;
      r_rcnt     <= '0;
      r_fidx     <= '0;
      r_tick_cnt <= '0;
      r_acc      <= '0;
      r_snd      <= 1'b0;
      for (int i = 0; i < N_OSC; i++) begin
        r_freq[i]  <= '0;
        r_phase[i] <= '0;
      end
    end else begin
      if (w_sweep_en) begin
        if (r_rcnt == RCNT_LAST) begin
          r_rcnt     <= '0;
          r_r        <= w_r_next;
          r_dir_down <= w_dir_next;
        end else begin
          r_rcnt <= r_rcnt + RCNT_W'(1);
        end
      end
      if (x_valid) begin
        r_freq[r_fidx] <= w_freq_new;
        r_fidx <= (5'(r_fidx) >= w_n_eff - 5'd1) ? '0 : r_fidx + IDX_W'(1);
      end
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      if (w_tick) begin
        for (int i = 0; i < N_OSC; i++) r_phase[i] <= r_phase[i] + r_freq[i];
      end
      r_snd <= w_fire;
      r_acc <= w_fire ? 5'(w_acc_sum - {1'b0, w_n_eff}) : w_acc_sum[4:0];
    end
  end

  assign snd   = r_snd;
  assign r_out = r_r;

endmodule

// File: tb/tb_chaos_snd.sv
// Bench for chaos_snd: directed map/sweep/reset sequences followed by random
// mode and oscillator-count changes, checked against a behavioural model.
module tb_chaos_snd;

  localparam int FRAC    = 8;
  localparam int ITER    = 8;
  localparam int N_OSC   = 4;
  localparam int R_INC   = 2;
  localparam int R_MIN   = 'h200;
  localparam int R_MAX   = 'h208;
  localparam int R_STEP  = 4;
  localparam int SEED    = 'h40;
  localparam int FREQ    = 16384;
  // 200 * 2^14 / 16384 and 1200 * 2^14 / 16384; tick every 2^(14-12) clocks
  localparam int LO_INC  = 200;
  localparam int HI_INC  = 1200;
  localparam int TICK_P  = 4;
  localparam int PH_MOD  = 4096;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       map_mode = 1'b0;
  logic [1:0] sweep_mode = 2'b00;
  logic [4:0] n_active = 5'd1;
  logic       snd, x_valid;
  logic [7:0] x_out;
  logic [9:0] r_out;
  logic       t_snd, t_xv;
  logic [7:0] t_x;
  logic [9:0] t_r;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cyc, m_x, m_r, m_rcnt, m_fidx, m_acc;
  bit m_down, m_xv, m_snd;
  int m_freq [N_OSC];
  int m_phase[N_OSC];

  always #5 clk = ~clk;

  chaos_snd #(
    .N_OSC(N_OSC), .FRAC(FRAC), .ITER_LEN(ITER), .R_INC(R_INC),
    .R_MIN(R_MIN), .R_MAX(R_MAX), .R_STEP(R_STEP), .X_SEED(SEED),
    .FREQ(FREQ), .LO_F(200), .HI_F(1200), .PHASE_BITS(12), .FREQ_RES(0)
  ) u_dut (
    .clk(clk), .reset(reset), .map_mode(map_mode), .sweep_mode(sweep_mode),
    .n_active(n_active), .snd(snd), .x_out(x_out), .r_out(r_out), .x_valid(x_valid)
  );

  chaos_snd #(
    .N_OSC(N_OSC), .FRAC(FRAC), .ITER_LEN(ITER), .R_INC(R_INC),
    .R_MIN('h100), .X_SEED('h80), .FREQ(FREQ)
  ) u_tent (
    .clk(clk), .reset(reset), .map_mode(1'b1), .sweep_mode(2'b00),
    .n_active(5'd1), .snd(t_snd), .x_out(t_x), .r_out(t_r), .x_valid(t_xv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int map_next(input int x, input int r, input bit tent);
    longint p;
    int     nx;
    int     lo;
    if (tent) begin
      lo = (x < 256 - x) ? x : 256 - x;
      nx = (r * lo) / 512;
    end else begin
      p  = longint'(r) * x * (256 - x);
      nx = int'(p / 65536);
    end
    return (nx == 0) ? SEED : nx;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_x = SEED; m_r = R_MIN; m_down = 0; m_rcnt = 0;
    m_fidx = 0; m_acc = 0; m_xv = 0; m_snd = 0;
    for (int i = 0; i < N_OSC; i++) begin
      m_freq[i] = 0;
      m_phase[i] = 0;
    end
  endtask

  task automatic r_update();
    int nr;
    if (sweep_mode == 2'b01) begin
      nr = m_r + R_STEP;
      if (nr > R_MAX) nr = R_MIN;
    end else if (!m_down) begin
      nr = m_r + R_STEP;
      if (nr >= R_MAX) begin nr = R_MAX; m_down = 1; end
    end else begin
      nr = m_r - R_STEP;
      if (nr <= R_MIN) begin nr = R_MIN; m_down = 0; end
    end
    m_r = nr;
  endtask

  // One clock: advance the model by the rules for this edge, then compare.
  task automatic step();
    int neff, sum, old_x, old_r;
    bit old_xv;
    int old_phase[N_OSC];
    int old_freq [N_OSC];
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      neff = (n_active == 0) ? 1 : ((n_active > N_OSC) ? N_OSC : int'(n_active));
      old_phase = m_phase; old_freq = m_freq;
      old_xv = m_xv; old_x = m_x; old_r = m_r;
      sum = 0;
      for (int i = 0; i < neff; i++) if (old_phase[i] >= PH_MOD / 2) sum++;
      if (m_acc + sum >= neff) begin m_snd = 1; m_acc = m_acc + sum - neff; end
      else begin m_snd = 0; m_acc = m_acc + sum; end
      if (m_cyc % TICK_P == TICK_P - 1)
        for (int i = 0; i < N_OSC; i++) m_phase[i] = (old_phase[i] + old_freq[i]) % PH_MOD;
      if (old_xv) begin
        if (sweep_mode == 2'b01 || sweep_mode == 2'b10) begin
          m_rcnt++;
          if (m_rcnt == R_INC) begin m_rcnt = 0; r_update(); end
        end
        m_freq[m_fidx] = LO_INC + ((HI_INC - LO_INC) * old_x) / 256;
        m_fidx = (m_fidx >= neff - 1) ? 0 : m_fidx + 1;
      end
      m_xv = (m_cyc % ITER == ITER - 1);
      if (m_xv) m_x = map_next(old_x, old_r, map_mode);
      m_cyc++;
    end
    #1;
    check("snd", snd, m_snd);
    check("x_valid", x_valid, m_xv);
    check("x_out", x_out, m_x);
    check("r_out", r_out, m_r);
    check("tent_xv", t_xv, m_xv);
  endtask

  task automatic wait_xv(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (x_valid !== 1'b1 && k < ITER + 2);
    if (x_valid !== 1'b1) check({tag, "_timeout"}, x_valid, 1);
  endtask

  int tent_tbl[8] = '{'h40, 'h20, 'h10, 'h08, 'h04, 'h02, 'h01, 'h80};
  int pp_tbl[12]  = '{'h200, 'h200, 'h204, 'h204, 'h208, 'h208,
                      'h204, 'h204, 'h200, 'h200, 'h204, 'h204};
  int up_tbl[8]   = '{'h200, 'h200, 'h204, 'h204, 'h208, 'h208, 'h200, 'h200};

  initial begin
    int k;
    model_reset();
    // reset values
    repeat (3) step();
    check("rst_x", x_out, 'h40);
    check("rst_r", r_out, 'h200);
    check("rst_xv", x_valid, 0);
    check("rst_snd", snd, 0);
    check("rst_tent_x", t_x, 'h80);
    reset = 1'b0;

    // logistic hold with r=2.0, tent hold with r=1.0, one oscillator
    for (int i = 0; i < 8; i++) begin
      wait_xv("iter");
      if (i == 0) check("logi_1", x_out, 'h60);
      if (i == 1) check("logi_2", x_out, 'h78);
      check("tent_seq", t_x, tent_tbl[i]);
    end

    // n_active = 0 behaves as one oscillator
    n_active = 5'd0;
    repeat (60) step();

    // reset in the middle of an iteration
    k = 0;
    while (m_cyc % ITER != 5 && k < 20) begin step(); k++; end
    reset = 1'b1;
    step();
    check("midrst_xv", x_valid, 0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= ITER; i++) begin
      step();
      if (i < ITER) begin
        check("midrst_quiet", x_valid, 0);
        check("midrst_seed", x_out, SEED);
      end else begin
        check("midrst_first", x_valid, 1);
      end
    end

    // ping-pong sweep from reset
    reset = 1'b1; n_active = 5'd3;
    repeat (2) step();
    sweep_mode = 2'b10; reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_xv("pp");
      check("pp_r", r_out, pp_tbl[i]);
    end

    // up-wrap sweep from reset, tent map
    reset = 1'b1; n_active = 5'd7;
    repeat (2) step();
    sweep_mode = 2'b01; map_mode = 1'b1; reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_xv("up");
      check("up_r", r_out, up_tbl[i]);
    end

    // hold keeps r frozen, then resume ping-pong with retained direction
    sweep_mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_xv("hold");
      check("hold_r", r_out, 'h200);
    end
    sweep_mode = 2'b10; map_mode = 1'b0; n_active = 5'd4;
    repeat (80) step();

    // randomized mode / oscillator-count changes with occasional resets
    for (int s = 0; s < 2000; s++) begin
      if ($urandom_range(0, 19) == 0) n_active = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 29) == 0) map_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) sweep_mode = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chaos_snd.md
CHAOS_SND -- requirements
Module: chaos_snd

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  N_OSC, 4: square-wave oscillator count (1..16)
  FRAC, 8: fractional bits of x (0.FRAC) and r (2.FRAC)
  ITER_LEN, 100: clocks per map iteration (>= 2)
  R_INC, 1000: iterations between r updates (>= 1)
  R_MIN, 0x110: r reset/low bound; R_MAX, 0x3FF: r high bound; R_STEP, 4: r increment
  X_SEED, 0x80: x reset/reseed value (nonzero)
  FREQ, 25_200_000: clk Hz; LO_F, 200 / HI_F, 1200: Hz at x=0 / x=1
  PHASE_BITS, 12: NCO phase width; FREQ_RES, 0: log2 NCO resolution, Hz
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  reset  in  1  synchronous, active-high reset
  map_mode  in  1  0 logistic, 1 tent
  sweep_mode  in  2  00 hold, 01 up-wrap, 10 ping-pong, 11 = hold
  n_active  in  5  oscillators in use
  snd  out  1  PWM audio
  x_out  out  FRAC  current x
  r_out  out  FRAC+2  current r
  x_valid  out  1  one-cycle pulse: new x

Function
REQ-003 Iteration counter SHALL count 0..ITER_LEN-1; on count ITER_LEN-1 edge x_out SHALL load x_next and x_valid SHALL be high the following cycle (first pulse ITER_LEN cycles after reset release).
REQ-004 Logistic: x_next SHALL be floor(r*x*(2^FRAC - x) / 2^(2*FRAC)) with full-width product; tent: x_next SHALL be floor(r*min(x, 2^FRAC - x) / 2^(FRAC+1)); result always < 2^FRAC, no saturation.
REQ-005 If x_next computes to 0, x_out SHALL load X_SEED instead.
REQ-006 map_mode and r_out SHALL be sampled at the update edge; a map_mode change SHALL take effect at the next update.
REQ-007 r_counter SHALL advance on each x_valid, wrap R_INC-1 -> 0, and on wrap r SHALL update in the same edge: up-wrap r+R_STEP, exceeding R_MAX -> R_MIN; ping-pong steps by +/-R_STEP, clamping to bound and reversing direction on reaching R_MAX or R_MIN.
REQ-008 In hold, r and r_counter SHALL freeze; direction flag SHALL be retained across mode changes.
REQ-009 Effective count n_eff SHALL be n_active clamped to 1..N_OSC.
REQ-010 On each x_valid, freq[f_idx] SHALL load LO_INC + ((HI_INC-LO_INC)*x_out >> FRAC), LO_INC/HI_INC = F * 2^(PHASE_BITS+PHASE_DEC) / FREQ; f_idx SHALL advance, wrapping to 0 when >= n_eff-1 (also when n_eff shrinks below f_idx).
REQ-011 NCO tick SHALL pulse every 2^PHASE_DEC clocks, PHASE_DEC = clog2(FREQ)-PHASE_BITS-FREQ_RES; each tick phase[i] += freq[i] mod 2^PHASE_BITS; osc[i] = phase MSB.
REQ-012 Mixer: sum = count of high osc[i] with i < n_eff; acc+sum >= n_eff -> snd=1, acc <= acc+sum-n_eff, else snd=0, acc <= acc+sum; snd registered.

Reset
REQ-013 Reset SHALL set x_out=X_SEED, r_out=R_MIN, direction up, x_valid=0, snd=0, all counters, phases, freq, acc=0; reset mid-iteration SHALL abort it with no x_valid.

Structure
REQ-014 Shared package SHALL hold map_mode/sweep_mode encodings and LO_INC/HI_INC/PHASE_DEC derivation.
REQ-015 Map arithmetic and iteration counter SHALL be sub-module chaos_map_core (ports: clk, reset, map_mode, r, x, x_valid); sweep, NCOs, mixer stay in chaos_snd.

Verification
REQ-016 Logistic, R_MIN=0x200, hold, X_SEED=0x40 -> x_out 0x60, then 0x78 on successive x_valid.
REQ-017 Tent, R_MIN=0x100, hold, X_SEED=0x80 -> 0x40,0x20,...,0x01, then 0x80 (reseed).
REQ-018 Ping-pong, R_MIN=0x200, R_MAX=0x208, R_STEP=4, R_INC=2 -> r_out 200,204,208,204,200,204, changing every 2nd x_valid.
REQ-019 n_active=0 and n_active=1 -> only freq[0] written; snd equals osc[0] delayed 1 clock.
REQ-020 Reset asserted at iteration count 50 -> no x_valid; first x_valid ITER_LEN cycles after release, x_out=X_SEED before it.
